// File: rtl/dmem_pipelined_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pipelined_if
//  Description : Request/response bus between the memory stage and the
//                pipelined data memory. The master issues requests and
//                consumes responses; the slave is the memory.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dmem_pipelined_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [31:0]           resp_rdata;
    logic                  resp_error;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_error
    );
endinterface
`default_nettype wire

// File: rtl/dmem_pipelined.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pipelined
//  Description : Byte-addressable big-endian data memory with a valid/ready
//                request port, an in-order response pipeline of LATENCY
//                stages with backpressure, and alignment/range fault checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_pipelined #(
    parameter int SIZE       = 32768,
    parameter int LATENCY    = 1,
    parameter int ADDR_WIDTH = 32
) (
    input  wire logic       clock,
    input  wire logic       reset_n,
    dmem_pipelined_if.slave bus
);

    localparam int IDX_W = $clog2(SIZE);

    // Byte storage; deliberately not reset
    logic [7:0] mem [SIZE];

    // Response pipeline, index LATENCY-1 is the stage presented on the bus
    logic [LATENCY-1:0]       stage_valid;
    logic [LATENCY-1:0]       stage_error;
    logic [LATENCY-1:0][31:0] stage_rdata;

    logic                  advance;
    logic                  accept;
    logic [2:0]            nbytes_m1;
    logic                  misaligned;
    logic [ADDR_WIDTH:0]   last_addr;
    logic                  out_of_range;
    logic                  fault;
    logic [IDX_W-1:0]      base_addr;
    logic [IDX_W-1:0]      lane_addr [4];
    logic [7:0]            rbyte [4];
    logic [7:0]            sel_byte;
    logic [15:0]           sel_half;
    logic [31:0]           load_ext;
    logic [31:0]           load_data;
    logic [3:0]            lane_we;
    logic [7:0]            lane_wd [4];

    // Whole pipeline moves together; the port is ready exactly when it moves
    assign advance       = !stage_valid[LATENCY-1] || bus.resp_ready;
    assign accept        = bus.req_valid && advance;
    assign bus.req_ready = advance;

    assign bus.resp_valid = stage_valid[LATENCY-1];
    assign bus.resp_rdata = stage_rdata[LATENCY-1];
    assign bus.resp_error = stage_error[LATENCY-1];

    // Access width and alignment decode
    always_comb begin
        nbytes_m1  = 3'd0;
        misaligned = 1'b0;
        case (bus.req_size)
            2'd0: begin
                nbytes_m1  = 3'd0;
                misaligned = 1'b0;
            end
            2'd1: begin
                nbytes_m1  = 3'd1;
                misaligned = bus.req_addr[0];
            end
            default: begin
                nbytes_m1  = 3'd3;
                misaligned = |bus.req_addr[1:0];
            end
        endcase
    end

    // One extra bit keeps the end address from wrapping at the top of the space
    assign last_addr    = {1'b0, bus.req_addr} + (ADDR_WIDTH+1)'(nbytes_m1);
    assign out_of_range = last_addr >= (ADDR_WIDTH+1)'(SIZE);
    assign fault        = (bus.req_size == 2'd3) || misaligned || out_of_range;

    // All four bytes of the containing word; lane 0 is the most significant
    assign base_addr = bus.req_addr[IDX_W-1:0] & ~IDX_W'(3);

    // Read the containing word's bytes combinationally
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            lane_addr[k] = base_addr | IDX_W'(k);
            rbyte[k]     = mem[lane_addr[k]];
        end
    end

    // Select and extend load data; stores and faults return zero
    always_comb begin
        sel_byte = rbyte[bus.req_addr[1:0]];
        sel_half = bus.req_addr[1] ? {rbyte[2], rbyte[3]} : {rbyte[0], rbyte[1]};
        case (bus.req_size)
            2'd0:    load_ext = {{24{bus.req_signed & sel_byte[7]}}, sel_byte};
            2'd1:    load_ext = {{16{bus.req_signed & sel_half[15]}}, sel_half};
            default: load_ext = {rbyte[0], rbyte[1], rbyte[2], rbyte[3]};
        endcase
        load_data = (fault || bus.req_write) ? 32'h0 : load_ext;
    end

    // Byte-lane write enables for an accepted, non-faulting store
    always_comb begin
        lane_we = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            lane_wd[k] = 8'h00;
        end
        if (accept && bus.req_write && !fault) begin
            case (bus.req_size)
                2'd1: begin
                    lane_we[{bus.req_addr[1], 1'b0}] = 1'b1;
                    lane_wd[{bus.req_addr[1], 1'b0}] = bus.req_wdata[15:8];
                    lane_we[{bus.req_addr[1], 1'b1}] = 1'b1;
                    lane_wd[{bus.req_addr[1], 1'b1}] = bus.req_wdata[7:0];
                end
                2'd2: begin
                    lane_we    = 4'b1111;
                    lane_wd[0] = bus.req_wdata[31:24];
                    lane_wd[1] = bus.req_wdata[23:16];
                    lane_wd[2] = bus.req_wdata[15:8];
                    lane_wd[3] = bus.req_wdata[7:0];
                end
                default: begin
                    lane_we[bus.req_addr[1:0]] = 1'b1;
                    lane_wd[bus.req_addr[1:0]] = bus.req_wdata[7:0];
                end
            endcase
        end
    end

    // Commit store bytes at the acceptance edge
    always_ff @(posedge clock) begin
        for (int k = 0; k < 4; k++) begin
            if (lane_we[k]) begin
                mem[lane_addr[k]] <= lane_wd[k];
            end
        end
    end

    // Shift the response pipeline whenever the final stage can move on
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stage_valid <= '0;
            stage_error <= '0;
            stage_rdata <= '0;
        end else if (advance) begin
            stage_valid[0] <= accept;
            stage_error[0] <= accept && fault;
            stage_rdata[0] <= accept ? load_data : 32'h0;
            for (int i = 1; i < LATENCY; i++) begin
                stage_valid[i] <= stage_valid[i-1];
                stage_error[i] <= stage_error[i-1];
                stage_rdata[i] <= stage_rdata[i-1];
            end
        end
    end

endmodule
`default_nettype wire
